video_fetch_sched: RTL and testbench

- Per-dot scheduler for the PPU rendering pipeline: owns the dot and scanline counters and sequences every VRAM fetch slot (nametable, attribute, background pattern, sprite pattern).
- Arbitrates the shared VRAM bus between rendering fetches and CPU $2007 accesses.
- Emits the per-dot strobes and the video control word consumed by the shifters and the pixel compositor.

---
 rtl/video_fetch_sched.sv | 210 +++++++++++++++++++++
 tb/tb_video_fetch_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_sched.sv
// rtl/video_fetch_sched.sv - PPU dot/line counters, VRAM fetch slot sequencing and CPU bus arbitration
module video_fetch_sched #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VISIBLE_LINES   = 240
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_dot_clk,
  input  logic [7:0]  I_ppumask,
  input  logic        I_cpu_req,
  output logic        O_cpu_ack,
  output logic [8:0]  O_dot,
  output logic [8:0]  O_line,
  output logic [2:0]  O_fetch_kind,
  output logic        O_ale,
  output logic [2:0]  O_sprite_idx,
  output logic [15:0] O_control
);

  localparam logic [8:0] LP_LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] LP_SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LP_LAST_LINE = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] LP_VIS_LINES = 9'(VISIBLE_LINES);
  localparam logic [8:0] LP_VBL_LINE  = 9'(VISIBLE_LINES + 1);

  localparam logic [2:0] KIND_IDLE  = 3'd0;
  localparam logic [2:0] KIND_NT    = 3'd1;
  localparam logic [2:0] KIND_AT    = 3'd2;
  localparam logic [2:0] KIND_BG_LO = 3'd3;
  localparam logic [2:0] KIND_BG_HI = 3'd4;
  localparam logic [2:0] KIND_SP_LO = 3'd5;
  localparam logic [2:0] KIND_SP_HI = 3'd6;
  localparam logic [2:0] KIND_CPU   = 3'd7;

  // video control word bit positions
  localparam int CTL_LEFT_MOST_8  = 0;
  localparam int CTL_SHIFT_RELOAD = 1;
  localparam int CTL_INC_HORI     = 2;
  localparam int CTL_INC_VERT     = 3;
  localparam int CTL_COPY_HORI    = 4;
  localparam int CTL_COPY_VERT    = 5;
  localparam int CTL_VBLANK_SET   = 6;
  localparam int CTL_VBLANK_CLR   = 7;
  localparam int CTL_RENDERING    = 8;

  typedef enum logic {ST_ARMED, ST_HELD} cpu_state_t;

  cpu_state_t  r_cpu_state;
  cpu_state_t  w_cpu_state_next;
  logic [8:0]  r_dot;
  logic [8:0]  r_line;
  logic        r_parity;
  logic [2:0]  r_fetch_kind;
  logic [2:0]  r_sprite_idx;
  logic        r_ale;
  logic        r_cpu_ack;
  logic [15:0] r_control;

  logic [8:0]  w_next_dot;
  logic [8:0]  w_next_line;
  logic        w_frame_wrap;
  logic        w_render_en;
  logic        w_render_active;
  logic [2:0]  w_dot_lo;
  logic [1:0]  w_phase;
  logic [2:0]  w_kind;
  logic [2:0]  w_sprite_idx;
  logic        w_ale;
  logic [15:0] w_control;
  logic        w_grant;
  logic        w_unused_mask;

  // Greyscale, clipping and emphasis bits belong to the compositor, not the scheduler.
  assign w_unused_mask = ^{I_ppumask[7:5], I_ppumask[2:0]};

  assign w_render_en     = I_ppumask[3] | I_ppumask[4];
  assign w_render_active = w_render_en && ((w_next_line < LP_VIS_LINES) || (w_next_line == LP_LAST_LINE));
  assign w_dot_lo        = w_next_dot[2:0];

  // Position the next dot enable moves to, including the odd-frame short pre-render line.
  always_comb begin
    w_next_dot   = r_dot + 9'd1;
    w_next_line  = r_line;
    w_frame_wrap = 1'b0;
    if ((r_line == LP_LAST_LINE) && (r_dot == LP_SKIP_DOT) && r_parity && w_render_en) begin
      w_next_dot   = 9'd0;
      w_next_line  = 9'd0;
      w_frame_wrap = 1'b1;
    end else if (r_dot == LP_LAST_DOT) begin
      w_next_dot = 9'd0;
      if (r_line == LP_LAST_LINE) begin
        w_next_line  = 9'd0;
        w_frame_wrap = 1'b1;
      end else begin
        w_next_line = r_line + 9'd1;
      end
    end
  end

  // Fetch slot decode for the upcoming dot: slot phase is (dot-1)[2:1].
  always_comb begin
    case (w_dot_lo)
      3'd1, 3'd2: w_phase = 2'd0;
      3'd3, 3'd4: w_phase = 2'd1;
      3'd5, 3'd6: w_phase = 2'd2;
      default:    w_phase = 2'd3;
    endcase
    w_kind       = KIND_IDLE;
    w_ale        = 1'b0;
    w_sprite_idx = 3'd0;
    if (w_render_active && (w_next_dot != 9'd0)) begin
      w_ale = w_next_dot[0];
      if (w_next_dot >= 9'd337) begin
        w_kind = KIND_NT;
      end else if ((w_next_dot >= 9'd257) && (w_next_dot <= 9'd320)) begin
        w_sprite_idx = 3'((w_next_dot - 9'd257) >> 3);
        case (w_phase)
          2'd0:    w_kind = KIND_NT;
          2'd1:    w_kind = KIND_AT;
          2'd2:    w_kind = KIND_SP_LO;
          default: w_kind = KIND_SP_HI;
        endcase
      end else begin
        case (w_phase)
          2'd0:    w_kind = KIND_NT;
          2'd1:    w_kind = KIND_AT;
          2'd2:    w_kind = KIND_BG_LO;
          default: w_kind = KIND_BG_HI;
        endcase
      end
    end
  end

  // Per-dot strobes for the shifters, v/t register updates and vblank flag.
  always_comb begin
    w_control = 16'd0;
    w_control[CTL_LEFT_MOST_8]  = (w_next_line < LP_VIS_LINES) && (w_next_dot >= 9'd1) && (w_next_dot <= 9'd8);
    w_control[CTL_SHIFT_RELOAD] = w_render_active &&
        (((w_dot_lo == 3'd1) && (w_next_dot >= 9'd9) && (w_next_dot <= 9'd257)) ||
         (w_next_dot == 9'd329) || (w_next_dot == 9'd337));
    w_control[CTL_INC_HORI]     = w_render_active && (w_dot_lo == 3'd0) &&
        (((w_next_dot >= 9'd8) && (w_next_dot <= 9'd256)) || ((w_next_dot >= 9'd328) && (w_next_dot <= 9'd336)));
    w_control[CTL_INC_VERT]     = w_render_active && (w_next_dot == 9'd256);
    w_control[CTL_COPY_HORI]    = w_render_active && (w_next_dot == 9'd257);
    w_control[CTL_COPY_VERT]    = w_render_active && (w_next_line == LP_LAST_LINE) &&
        (w_next_dot >= 9'd280) && (w_next_dot <= 9'd304);
    w_control[CTL_VBLANK_SET]   = (w_next_line == LP_VBL_LINE) && (w_next_dot == 9'd1);
    w_control[CTL_VBLANK_CLR]   = (w_next_line == LP_LAST_LINE) && (w_next_dot == 9'd1);
    w_control[CTL_RENDERING]    = w_render_active;
  end

  // CPU arbitration state: one grant per request, re-armed once the request drops.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) r_cpu_state <= ST_ARMED;
    else         r_cpu_state <= w_cpu_state_next;
  end

  // CPU grant decision: only on a dot enable that lands outside rendering.
  always_comb begin
    w_cpu_state_next = r_cpu_state;
    w_grant          = 1'b0;
    case (r_cpu_state)
      ST_ARMED: begin
        if (I_cpu_req && I_dot_clk && !w_render_active) begin
          w_grant          = 1'b1;
          w_cpu_state_next = ST_HELD;
        end
      end
      default: begin
        if (!I_cpu_req) w_cpu_state_next = ST_ARMED;
      end
    endcase
  end

  // Counters and registered per-dot outputs, advanced only on dot enables.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      r_dot        <= 9'd0;
      r_line       <= 9'd0;
      r_parity     <= 1'b0;
      r_fetch_kind <= KIND_IDLE;
      r_ale        <= 1'b0;
      r_sprite_idx <= 3'd0;
      r_control    <= 16'd0;
      r_cpu_ack    <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      if (I_dot_clk) begin
        r_dot        <= w_next_dot;
        r_line       <= w_next_line;
        r_parity     <= r_parity ^ w_frame_wrap;
        r_fetch_kind <= w_grant ? KIND_CPU : w_kind;
        r_ale        <= w_ale;
        r_sprite_idx <= w_sprite_idx;
        r_control    <= w_control;
        r_cpu_ack    <= w_grant;
      end
    end
  end

  assign O_dot        = r_dot;
  assign O_line       = r_line;
  assign O_fetch_kind = r_fetch_kind;
  assign O_ale        = r_ale;
  assign O_sprite_idx = r_sprite_idx;
  assign O_control    = r_control;
  assign O_cpu_ack    = r_cpu_ack;

endmodule

// File: tb/tb_video_fetch_sched.sv
// tb/tb_video_fetch_sched.sv - randomized model-checked bench for video_fetch_sched
module tb_video_fetch_sched;

  // Short frame keeps several full frames inside the cycle budget; dot timing stays real.
  localparam int DPL = 341;
  localparam int LPF = 16;
  localparam int VIS = 10;

  logic        clk;
  logic        rst;
  logic        dot_clk;
  logic [7:0]  mask;
  logic        cpu_req;
  logic        cpu_ack;
  logic [8:0]  dot;
  logic [8:0]  line;
  logic [2:0]  kind;
  logic        ale;
  logic [2:0]  sidx;
  logic [15:0] ctrl;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  bit rnd_req = 0;
  bit rnd_mask = 0;

  int m_dot, m_line;
  bit m_par, m_armed;
  bit mb_en, mb_ra, mb_g;
  int e_dot, e_line, e_kind, e_ale, e_idx, e_ctrl, e_ack;

  video_fetch_sched #(
    .DOTS_PER_LINE(DPL),
    .LINES_PER_FRAME(LPF),
    .VISIBLE_LINES(VIS)
  ) dut (
    .I_clock(clk),
    .I_reset(rst),
    .I_dot_clk(dot_clk),
    .I_ppumask(mask),
    .I_cpu_req(cpu_req),
    .O_cpu_ack(cpu_ack),
    .O_dot(dot),
    .O_line(line),
    .O_fetch_kind(kind),
    .O_ale(ale),
    .O_sprite_idx(sidx),
    .O_control(ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, required %0d (line %0d dot %0d, t=%0t)", nm, act, exp, line, dot, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, got no event, required one", nm);
  endtask

  function automatic int exp_kind(input int d, input bit ra);
    int slot;
    if (!ra || d == 0) return 0;
    if (d >= 337) return 1;
    slot = ((d - 1) / 2) % 4;
    if (d >= 257 && d <= 320) return (slot < 2) ? slot + 1 : slot + 3;
    return slot + 1;
  endfunction

  function automatic int exp_ctrl(input int d, input int l, input bit ra);
    int c = 0;
    if (l < VIS && d >= 1 && d <= 8) c |= 1 << 0;
    if (ra && ((d % 8 == 1 && d >= 9 && d <= 257) || d == 329 || d == 337)) c |= 1 << 1;
    if (ra && d % 8 == 0 && ((d >= 8 && d <= 256) || (d >= 328 && d <= 336))) c |= 1 << 2;
    if (ra && d == 256) c |= 1 << 3;
    if (ra && d == 257) c |= 1 << 4;
    if (ra && l == LPF - 1 && d >= 280 && d <= 304) c |= 1 << 5;
    if (l == VIS + 1 && d == 1) c |= 1 << 6;
    if (l == LPF - 1 && d == 1) c |= 1 << 7;
    if (ra) c |= 1 << 8;
    return c;
  endfunction

  // Reference model: position walk plus expected outputs for the dot just entered.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_dot = 0; m_line = 0; m_par = 0; m_armed = 1;
      e_dot = 0; e_line = 0; e_kind = 0; e_ale = 0; e_idx = 0; e_ctrl = 0; e_ack = 0;
    end else begin
      mb_g  = 0;
      e_ack = 0;
      if (dot_clk) begin
        mb_en = mask[3] | mask[4];
        if (m_line == LPF - 1 && m_dot == DPL - 2 && m_par && mb_en) begin
          m_dot = 0; m_line = 0; m_par = !m_par;
        end else begin
          m_dot++;
          if (m_dot == DPL) begin
            m_dot = 0;
            m_line++;
            if (m_line == LPF) begin
              m_line = 0;
              m_par  = !m_par;
            end
          end
        end
        mb_ra  = mb_en && (m_line < VIS || m_line == LPF - 1);
        mb_g   = cpu_req && m_armed && !mb_ra;
        e_dot  = m_dot;
        e_line = m_line;
        e_kind = mb_g ? 7 : exp_kind(m_dot, mb_ra);
        e_ale  = (mb_ra && m_dot % 2 == 1) ? 1 : 0;
        e_idx  = (mb_ra && m_dot >= 257 && m_dot <= 320) ? (m_dot - 257) / 8 : 0;
        e_ctrl = exp_ctrl(m_dot, m_line, mb_ra);
        e_ack  = mb_g ? 1 : 0;
      end
      if (mb_g) m_armed = 0;
      else if (!cpu_req) m_armed = 1;
    end
  end

  // Compare every cycle, a few ns after the active edge.
  initial forever begin
    @(posedge clk);
    #3;
    if (chk_en) begin
      chk("m_dot", int'(dot), e_dot);
      chk("m_line", int'(line), e_line);
      chk("m_kind", int'(kind), e_kind);
      chk("m_ale", int'(ale), e_ale);
      chk("m_sprite_idx", int'(sidx), e_idx);
      chk("m_control", int'(ctrl), e_ctrl);
      chk("m_cpu_ack", int'(cpu_ack), e_ack);
    end
  end

  task automatic tick();
    @(negedge clk);
    dot_clk = ($urandom_range(0, 3) != 0);
    if (rnd_req && $urandom_range(0, 15) == 0) cpu_req = ~cpu_req;
    if (rnd_mask && $urandom_range(0, 99) == 0) mask = 8'($urandom);
  endtask

  task automatic wait_pos(input int l, input int d, input string nm);
    int n = 0;
    tick();
    while (!(int'(line) == l && int'(dot) == d) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) timeout_fail(nm);
  endtask

  task automatic wait_change(input string nm);
    int n = 0;
    int od;
    od = int'(dot);
    tick();
    while (int'(dot) == od && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeout_fail(nm);
  endtask

  task automatic wait_ack(input int bound, input string nm);
    int n = 0;
    tick();
    while (!cpu_ack && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) timeout_fail(nm);
  endtask

  initial begin
    int kt[8];
    int at[8];
    int spk[4];
    int acks;
    kt  = '{1, 1, 2, 2, 3, 3, 4, 4};
    at  = '{1, 0, 1, 0, 1, 0, 1, 0};
    spk = '{5, 5, 6, 6};
    rst = 1'b1; dot_clk = 1'b0; mask = 8'h00; cpu_req = 1'b0;
    repeat (3) tick();
    chk_en = 1;
    chk("reset_dot", int'(dot), 0);
    chk("reset_line", int'(line), 0);
    chk("reset_control", int'(ctrl), 0);
    rst  = 1'b0;
    mask = 8'h18;

    // mid-frame reset
    wait_pos(7, 200, "reach_7_200");
    rst = 1'b1;
    repeat (2) begin
      tick();
      chk("midreset_dot", int'(dot), 0);
      chk("midreset_line", int'(line), 0);
      chk("midreset_control", int'(ctrl), 0);
    end
    rst = 1'b0;
    wait_change("restart");
    chk("restart_dot", int'(dot), 1);
    chk("restart_line", int'(line), 0);

    // background fetch slots
    for (int i = 1; i <= 8; i++) begin
      wait_pos(5, i, "reach_bg");
      chk("bg_kind", int'(kind), kt[i-1]);
      chk("bg_ale", int'(ale), at[i-1]);
    end
    chk("inc_hori_d8", int'(ctrl[2]), 1);
    wait_pos(5, 9, "reach_d9");
    chk("shift_reload_d9", int'(ctrl[1]), 1);
    wait_pos(5, 257, "reach_d257");
    chk("copy_hori_d257", int'(ctrl[4]), 1);
    for (int i = 0; i < 4; i++) begin
      wait_pos(5, 261 + i, "reach_sp");
      chk("sp_kind", int'(kind), spk[i]);
      chk("sp_idx0", int'(sidx), 0);
    end
    wait_pos(5, 313, "reach_d313");
    chk("sp_idx7", int'(sidx), 7);

    // CPU request stalls through rendering
    wait_pos(6, 0, "reach_6_0");
    cpu_req = 1'b1;
    wait_ack(10000, "render_ack");
    chk("stall_ack_line", int'(line), VIS);
    chk("stall_ack_dot", int'(dot), 0);
    chk("stall_ack_kind", int'(kind), 7);
    acks = 0;
    repeat (40) begin tick(); if (cpu_ack) acks++; end
    chk("held_req_single_ack", acks, 0);
    cpu_req = 1'b0;

    // vblank strobes, copy_vert and odd-frame skip with bg only
    mask = 8'h08;
    wait_pos(VIS + 1, 1, "reach_vbl_set");
    chk("vblank_set", int'(ctrl[6]), 1);
    chk("rendering_in_vblank", int'(ctrl[8]), 0);
    wait_pos(LPF - 1, 1, "reach_vbl_clr");
    chk("vblank_clr", int'(ctrl[7]), 1);
    chk("rendering_prerender", int'(ctrl[8]), 1);
    wait_pos(LPF - 1, 280, "reach_cv280");
    chk("copy_vert_280", int'(ctrl[5]), 1);
    wait_pos(LPF - 1, 304, "reach_cv304");
    chk("copy_vert_304", int'(ctrl[5]), 1);
    wait_pos(LPF - 1, 305, "reach_cv305");
    chk("copy_vert_305", int'(ctrl[5]), 0);
    wait_pos(LPF - 1, 339, "reach_even_339");
    wait_change("even_340");
    chk("even_frame_dot", int'(dot), 340);
    wait_pos(LPF - 1, 339, "reach_odd_339");
    wait_change("odd_skip");
    chk("odd_skip_dot", int'(dot), 0);
    chk("odd_skip_line", int'(line), 0);

    // rendering disabled: immediate CPU grant, no skip, no copy_vert
    mask = 8'h00;
    tick();
    cpu_req = 1'b1;
    wait_ack(20, "idle_ack");
    chk("idle_ack_kind", int'(kind), 7);
    acks = 0;
    repeat (30) begin tick(); if (cpu_ack) acks++; end
    chk("idle_held_single_ack", acks, 0);
    cpu_req = 1'b0;
    wait_pos(5, 3, "reach_off_5_3");
    chk("off_kind", int'(kind), 0);
    chk("off_left_most_8", int'(ctrl[0]), 1);
    wait_pos(VIS + 1, 1, "reach_off_vbl");
    chk("off_vblank_set", int'(ctrl[6]), 1);
    wait_pos(LPF - 1, 290, "reach_off_cv");
    chk("off_copy_vert", int'(ctrl[5]), 0);
    wait_pos(LPF - 1, 339, "reach_off_even");
    wait_change("off_even_step");
    wait_pos(LPF - 1, 339, "reach_off_odd");
    wait_change("off_odd_step");
    chk("off_odd_no_skip", int'(dot), 340);

    // randomized traffic with a reset in the middle
    rnd_req  = 1;
    rnd_mask = 1;
    repeat (4000) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4000) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
